// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ local requesters share one AXI4-Lite master port.
// Each granted command is run to completion (AW+W+B or AR+R) before the next grant.
module axi4_lite_req_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 req_we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 done,
    output logic [DATA_WIDTH-1:0]              rdata_out,
    output logic [1:0]                         resp_out,
    output logic                               busy,
    output logic                               awvalid,
    input  logic                               awready,
    output logic [ADDRESS_WIDTH-1:0]           awaddr,
    output logic                               wvalid,
    input  logic                               wready,
    output logic [DATA_WIDTH-1:0]              wdata,
    output logic [DATA_WIDTH/8-1:0]            wstrb,
    input  logic                               bvalid,
    output logic                               bready,
    input  logic [1:0]                         bresp,
    output logic                               arvalid,
    input  logic                               arready,
    output logic [ADDRESS_WIDTH-1:0]           araddr,
    input  logic                               rvalid,
    output logic                               rready,
    input  logic [DATA_WIDTH-1:0]              rdata,
    input  logic [1:0]                         rresp,
    output logic [2:0]                         dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // valid, once raised, is held with stable payload until that edge.
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_RESP = 3'd2,
        RD_AR   = 3'd3,
        RD_DATA = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         win_q, win_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [1:0]               resp_q, resp_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     bready_q, bready_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]        wstrb_q, wstrb_d;

    logic                     found;
    logic [PTR_W-1:0]         cand;
    logic [PTR_W-1:0]         win_idx;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = '0;
        done_d    = '0;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d          = win_idx;
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    if (req_we[win_idx]) begin
                        awaddr_d  = req_addr[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        wdata_d   = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        wstrb_d   = req_wstrb[win_idx*STRB_W +: STRB_W];
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        araddr_d  = req_addr[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W retire independently; a low valid means that channel is already done.
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid && bready_q) begin
                    bready_d      = 1'b0;
                    done_d[win_q] = 1'b1;
                    resp_d        = bresp;
                    state_d       = IDLE;
                end
            end
            RD_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid && rready_q) begin
                    rready_d      = 1'b0;
                    rdata_d       = rdata;
                    resp_d        = rresp;
                    done_d[win_q] = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata_out   = rdata_q;
    assign resp_out    = resp_q;
    assign busy        = (state_q != IDLE);
    assign awvalid     = awvalid_q;
    assign awaddr      = awaddr_q;
    assign wvalid      = wvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign bready      = bready_q;
    assign arvalid     = arvalid_q;
    assign araddr      = araddr_q;
    assign rready      = rready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench for axi4_lite_req_arbiter: the slave side is driven cycle by cycle,
// and every expected value below is worked out by hand from the intended behaviour.
module tb_axi4_lite_req_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_AW_W = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_DATA = 3'd4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_we, gnt, done;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic [DW-1:0]   rdata_out, wdata, rdata;
    logic [1:0]      resp_out, bresp, rresp;
    logic            busy, awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [AW-1:0]   awaddr, araddr;
    logic [SW-1:0]   wstrb;
    logic [2:0]      dbg_state;

    int checks   = 0;
    int failures = 0;

    axi4_lite_req_arbiter #(.NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .gnt(gnt), .done(done), .rdata_out(rdata_out),
        .resp_out(resp_out), .busy(busy),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .dbg_state_o(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int idx, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [SW-1:0] st);
        req_we[idx]              = we;
        req_addr[idx*AW +: AW]   = addr;
        req_wdata[idx*DW +: DW]  = wd;
        req_wstrb[idx*SW +: SW]  = st;
    endtask

    // Assumes IDLE, the command already posted and awready=wready=1.
    task automatic serve_write(input string tag, input logic [N-1:0] exp_g,
                               input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wd,
                               input logic [1:0] br);
        tick();
        check_eq({tag, "_gnt"}, 64'(gnt), 64'(exp_g));
        check_eq({tag, "_awaddr"}, 64'(awaddr), 64'(exp_addr));
        check_eq({tag, "_wdata"}, 64'(wdata), 64'(exp_wd));
        req = req & ~exp_g;
        tick();
        check_eq({tag, "_bready"}, 64'(bready), 64'd1);
        check_eq({tag, "_awvalid_low"}, 64'(awvalid), 64'd0);
        bvalid = 1'b1;
        bresp  = br;
        tick();
        check_eq({tag, "_done"}, 64'(done), 64'(exp_g));
        check_eq({tag, "_resp"}, 64'(resp_out), 64'(br));
        check_eq({tag, "_gnt_idle"}, 64'(gnt), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    // Assumes IDLE, the command already posted and arready=1.
    task automatic serve_read(input string tag, input logic [N-1:0] exp_g,
                              input logic [AW-1:0] exp_addr, input logic [DW-1:0] rd,
                              input logic [1:0] rr);
        tick();
        check_eq({tag, "_gnt"}, 64'(gnt), 64'(exp_g));
        check_eq({tag, "_arvalid"}, 64'(arvalid), 64'd1);
        check_eq({tag, "_araddr"}, 64'(araddr), 64'(exp_addr));
        req = req & ~exp_g;
        tick();
        check_eq({tag, "_rready"}, 64'(rready), 64'd1);
        check_eq({tag, "_arvalid_low"}, 64'(arvalid), 64'd0);
        rvalid = 1'b1;
        rdata  = rd;
        rresp  = rr;
        tick();
        check_eq({tag, "_done"}, 64'(done), 64'(exp_g));
        check_eq({tag, "_rdata"}, 64'(rdata_out), 64'(rd));
        check_eq({tag, "_resp"}, 64'(resp_out), 64'(rr));
        check_eq({tag, "_rready_low"}, 64'(rready), 64'd0);
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_state", 64'(dbg_state), 64'(S_IDLE));
        check_eq("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check_eq("rst_gnt_done", 64'({gnt, done}), 64'd0);
        check_eq("rst_data", 64'({rdata_out, resp_out}), 64'd0);
        check_eq("rst_addr", 64'({awaddr, araddr}), 64'd0);
        check_eq("rst_wpayload", 64'({wdata, wstrb}), 64'd0);
        rst_n = 1'b1;

        // Single write from requester 0, bvalid arriving two cycles after bready
        set_cmd(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
        req = 2'b01; awready = 1'b1; wready = 1'b1;
        tick();
        check_eq("w1_gnt", 64'(gnt), 64'h1);
        check_eq("w1_awvalid", 64'(awvalid), 64'd1);
        check_eq("w1_wvalid", 64'(wvalid), 64'd1);
        check_eq("w1_awaddr", 64'(awaddr), 64'h10);
        check_eq("w1_wdata", 64'(wdata), 64'hA5A5_A5A5);
        check_eq("w1_wstrb", 64'(wstrb), 64'hF);
        check_eq("w1_busy", 64'(busy), 64'd1);
        check_eq("w1_state", 64'(dbg_state), 64'(S_WR_AW_W));
        req = 2'b00;
        tick();
        check_eq("w1_gnt_pulse", 64'(gnt), 64'd0);
        check_eq("w1_valids_low", 64'({awvalid, wvalid}), 64'd0);
        check_eq("w1_bready", 64'(bready), 64'd1);
        check_eq("w1_state_resp", 64'(dbg_state), 64'(S_WR_RESP));
        tick();
        check_eq("w1_bready_hold", 64'(bready), 64'd1);
        check_eq("w1_no_early_done", 64'(done), 64'd0);
        bvalid = 1'b1;
        tick();
        check_eq("w1_done", 64'(done), 64'h1);
        check_eq("w1_resp", 64'(resp_out), 64'd0);
        check_eq("w1_bready_low", 64'(bready), 64'd0);
        check_eq("w1_idle", 64'(busy), 64'd0);
        bvalid = 1'b0;
        tick();
        check_eq("w1_done_pulse", 64'(done), 64'd0);

        // Read from requester 1 with arready held off: arvalid high for 4 cycles
        set_cmd(1, 1'b0, 32'h20, 32'h0, 4'h0);
        req = 2'b10; arready = 1'b0;
        tick();
        check_eq("r1_gnt", 64'(gnt), 64'h2);
        check_eq("r1_araddr", 64'(araddr), 64'h20);
        check_eq("r1_no_aw", 64'({awvalid, wvalid}), 64'd0);
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("r1_arvalid_c%0d", i), 64'(arvalid), 64'd1);
            tick();
        end
        check_eq("r1_arvalid_c3", 64'(arvalid), 64'd1);
        arready = 1'b1;
        tick();
        check_eq("r1_arvalid_low", 64'(arvalid), 64'd0);
        check_eq("r1_rready", 64'(rready), 64'd1);
        check_eq("r1_state", 64'(dbg_state), 64'(S_RD_DATA));
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick();
        check_eq("r1_done", 64'(done), 64'h2);
        check_eq("r1_rdata", 64'(rdata_out), 64'hDEAD_BEEF);
        check_eq("r1_resp", 64'(resp_out), 64'd0);
        rvalid = 1'b0; rdata = '0;

        // Both requesters writing: 0 then 1, twice, as the pointer wraps
        awready = 1'b1; wready = 1'b1;
        set_cmd(0, 1'b1, 32'h100, 32'h1111_1111, 4'hF);
        set_cmd(1, 1'b1, 32'h104, 32'h2222_2222, 4'hF);
        req = 2'b11;
        serve_write("rr_a0", 2'b01, 32'h100, 32'h1111_1111, 2'b00);
        serve_write("rr_a1", 2'b10, 32'h104, 32'h2222_2222, 2'b00);
        req = 2'b11;
        serve_write("rr_b0", 2'b01, 32'h100, 32'h1111_1111, 2'b00);
        serve_write("rr_b1", 2'b10, 32'h104, 32'h2222_2222, 2'b00);

        // W accepted two cycles before AW; bready waits for both
        awready = 1'b0; wready = 1'b1;
        set_cmd(0, 1'b1, 32'h40, 32'h3333_3333, 4'h3);
        req = 2'b01;
        tick();
        check_eq("split_gnt", 64'(gnt), 64'h1);
        req = 2'b00;
        tick();
        check_eq("split_wvalid_low", 64'(wvalid), 64'd0);
        check_eq("split_awvalid_hold1", 64'(awvalid), 64'd1);
        check_eq("split_bready_wait1", 64'(bready), 64'd0);
        check_eq("split_awaddr_stable", 64'(awaddr), 64'h40);
        wready = 1'b0;
        tick();
        check_eq("split_awvalid_hold2", 64'(awvalid), 64'd1);
        check_eq("split_wvalid_stays_low", 64'(wvalid), 64'd0);
        check_eq("split_bready_wait2", 64'(bready), 64'd0);
        awready = 1'b1;
        tick();
        check_eq("split_awvalid_low", 64'(awvalid), 64'd0);
        check_eq("split_bready", 64'(bready), 64'd1);
        bvalid = 1'b1; bresp = 2'b00; wready = 1'b1;
        tick();
        check_eq("split_done", 64'(done), 64'h1);
        bvalid = 1'b0;

        // SLVERR read passes through; the next request is then granted
        arready = 1'b1;
        set_cmd(0, 1'b0, 32'h80, 32'h0, 4'h0);
        req = 2'b01;
        serve_read("rd_err", 2'b01, 32'h80, 32'h1234_5678, 2'b10);
        set_cmd(1, 1'b1, 32'h90, 32'h4444_4444, 4'hF);
        req = 2'b10;
        serve_write("after_err", 2'b10, 32'h90, 32'h4444_4444, 2'b11);
        check_eq("after_err_rdata_kept", 64'(rdata_out), 64'h1234_5678);

        // Reset while waiting for B: everything drops, no done, pointer back to 0
        set_cmd(0, 1'b1, 32'h200, 32'h5555_5555, 4'hF);
        req = 2'b01;
        tick();
        check_eq("rstmid_gnt", 64'(gnt), 64'h1);
        req = 2'b00;
        tick();
        check_eq("rstmid_in_resp", 64'(dbg_state), 64'(S_WR_RESP));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check_eq("rstmid_busy", 64'(busy), 64'd0);
        check_eq("rstmid_state", 64'(dbg_state), 64'(S_IDLE));
        bvalid = 1'b1;
        tick();
        check_eq("rstmid_no_done", 64'(done), 64'd0);
        bvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        check_eq("rstmid_no_done_after", 64'(done), 64'd0);
        set_cmd(0, 1'b1, 32'h300, 32'h6666_6666, 4'hF);
        set_cmd(1, 1'b1, 32'h304, 32'h7777_7777, 4'hF);
        req = 2'b11;
        serve_write("post_rst0", 2'b01, 32'h300, 32'h6666_6666, 2'b00);
        serve_write("post_rst1", 2'b10, 32'h304, 32'h7777_7777, 2'b00);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
- Round-robin scheduler that shares one AXI4-Lite master port between NUM_REQ local requesters.
- Each requester posts a single read or write command. The block grants one requester at a time and runs the full AXI4-Lite transaction itself (AW+W+B or AR+R).
- It returns the read data and response to the winning requester.
- It sits between local control logic and the AXI4-Lite interconnect, in front of slave VIPs or slave RTL.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDRESS_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (multiple of 8)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester command request (level)
req_we  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wstrb  in  NUM_REQ*(DATA_WIDTH/8)  packed write strobes
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: command captured
done  out  NUM_REQ  one-hot, 1-cycle pulse: transaction complete
rdata_out  out  DATA_WIDTH  read data, valid with done (read only)
resp_out  out  2  BRESP or RRESP, valid with done
busy  out  1  high in any state except IDLE
awvalid/awready/awaddr  out/in/out  1/1/ADDRESS_WIDTH  write address channel
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel
bvalid/bready/bresp  in/out/in  1/1/2  write response channel
arvalid/arready/araddr  out/in/out  1/1/ADDRESS_WIDTH  read address channel
rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  read data channel

Behaviour:
- Reset (async, rst_n=0) clears all outputs:
  - valids, readies, gnt, done, busy, rdata_out, resp_out, awaddr, araddr, wdata, wstrb all 0.
  - State IDLE; round-robin pointer set so requester 0 has highest priority.
  - Reset mid-transaction drops all valids immediately; no completion or done is issued.
- States: IDLE, WR_AW_W, WR_RESP, RD_AR, RD_DATA.
- IDLE, when any req=1 at edge N:
  - Winner is the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - At edge N: gnt[winner]=1 for one cycle, the command is registered, and the pointer becomes winner+1 mod NUM_REQ.
  - Write command: awvalid=wvalid=1 from edge N, go to WR_AW_W.
  - Read command: arvalid=1 from edge N, go to RD_AR.
- Requester protocol:
  - A requester holds req and its command stable until it sees gnt.
  - A req still high in the cycle after gnt is a new command.
  - A requester may deassert req before gnt; it simply loses eligibility.
- WR_AW_W:
  - awvalid and wvalid each stay high until their own handshake (valid&&ready), then drop independently.
  - Address and data are stable while the corresponding valid is high.
  - When both handshakes are complete (including the same cycle), assert bready=1 and go to WR_RESP.
- WR_RESP:
  - On bvalid&&bready: bready=0, done[winner]=1, resp_out=bresp, rdata_out unchanged, go to IDLE.
- RD_AR:
  - arvalid holds until arready, then arvalid=0, rready=1, go to RD_DATA.
- RD_DATA:
  - On rvalid&&rready: rready=0, rdata_out=rdata, resp_out=rresp, done[winner]=1, go to IDLE.
- Latency and turnaround:
  - The next grant occurs no earlier than the edge after done (one IDLE cycle minimum).
  - Only one outstanding transaction at a time; AW/W and AR are never active together.
- Fixed behaviours:
  - No timeout; a stalled slave holds the block in its state indefinitely.
  - Valids are never withdrawn before the handshake.
  - SLVERR/DECERR responses are passed through on resp_out unmodified; no retry.

Test Plan:
- Reset, then req[0]=1 write addr 0x10 wdata 0xA5A5A5A5 wstrb 0xF, slave awready=wready=1, bvalid 2 cycles later with bresp=0 -> gnt[0] pulse 1 cycle after req, awaddr=0x10 and wdata=0xA5A5A5A5 on AW/W, done[0] pulse with resp_out=0.
- req[1] read addr 0x20, slave arready delayed 3 cycles, rdata=0xDEADBEEF rresp=0 -> arvalid stays high 4 cycles, done[1] with rdata_out=0xDEADBEEF.
- req[0] and req[1] both high from reset, both writes -> requester 0 served first, then 1; next 0/1 pair served 0 then 1 again (pointer wraps).
- wready asserted 2 cycles before awready -> wvalid drops after its handshake while awvalid is held; bready rises only after both handshakes.
- Read returning rresp=2'b10 -> resp_out=2'b10 with done; block returns to IDLE and grants the next request.
- rst_n pulsed low while in WR_RESP -> all valids/readies 0 asynchronously, no done pulse, busy=0, next request serves requester 0 first.
